led_scan_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 26 ++
 rtl/led_scan_div.sv | 60 ++++++
 rtl/led_scan_ctrl.sv | 92 +++++++++
 tb/tb_led_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED digit scanner.
//   onehot_sel : one-hot vector with bit idx set (zero if idx >= n)
//   apply_pol  : optional inversion of a select vector for active-low pins
//   ptr_width  : width of a digit index for n digits (minimum 1)
package led_pkg;

  localparam int unsigned MAX_DIGITS = 16;

  typedef logic [MAX_DIGITS-1:0] sel_vec_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic sel_vec_t onehot_sel(input int unsigned idx, input int unsigned n);
    sel_vec_t v;
    v = '0;
    if (idx < n) v = sel_vec_t'(1) << idx;
    return v;
  endfunction

  function automatic sel_vec_t apply_pol(input sel_vec_t v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/led_scan_div.sv
// Scan timebase: slot divider plus digit pointer.
//   i_clk, i_rst     : clock, async active-high reset
//   i_en             : advance enable; both counters freeze when low
//   o_div_cnt        : cycle index inside the current slot (registered)
//   o_ptr            : current digit slot (registered)
//   o_slot_start_c   : combinational, high when o_div_cnt is 0
module led_scan_div
  import led_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned DIV_W    = $clog2(CLK_DIV),
  parameter int unsigned PTR_W    = ptr_width(N_DIGITS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [DIV_W-1:0] o_div_cnt,
  output logic [PTR_W-1:0] o_ptr,
  output logic             o_slot_start_c
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             tc;

  // Next-state: count within the slot, step the pointer on terminal count.
  always_comb begin
    div_cnt_d = div_cnt_q;
    ptr_d     = ptr_q;
    tc        = (div_cnt_q == DIV_LAST);
    if (i_en) begin
      if (tc) begin
        div_cnt_d = '0;
        // Explicit wrap keeps the pointer in range for non-power-of-2 counts.
        ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign o_div_cnt      = div_cnt_q;
  assign o_ptr          = ptr_q;
  assign o_slot_start_c = (div_cnt_q == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed LED digit scanner with PWM brightness and per-digit blanking.
//   i_clk, i_rst    : clock, async active-high reset
//   i_en            : scan enable (freezes timebase, blanks selects when low)
//   i_brightness    : duty level, sampled at the start of each slot
//   i_digit_mask    : 1 = digit shown, 0 = digit blanked (slot still used)
//   o_cs            : registered one-hot digit select, polarity per CS_ACTIVE_LOW
//   o_ptr           : registered index of the current slot (drives segment mux)
//   o_frame_start   : registered pulse on the first cycle of slot 0
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned CLK_DIV       = 50000,
  parameter int unsigned PWM_BITS      = 4,
  parameter bit          CS_ACTIVE_LOW = 1'b0,
  localparam int unsigned PTR_W        = ptr_width(N_DIGITS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_brightness,
  input  logic [N_DIGITS-1:0] i_digit_mask,
  output logic [N_DIGITS-1:0] o_cs,
  output logic [PTR_W-1:0]    o_ptr,
  output logic                o_frame_start
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam sel_vec_t    CS_IDLE_FULL = apply_pol('0, CS_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] CS_IDLE = CS_IDLE_FULL[N_DIGITS-1:0];

  logic [DIV_W-1:0]    div_cnt;
  logic [PTR_W-1:0]    ptr;
  logic                slot_start_c;

  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [N_DIGITS-1:0] cs_q, cs_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                frame_q, frame_d;
  logic [PWM_BITS-1:0] phase;
  logic                pwm_on;
  logic                active;

  led_scan_div #(
    .N_DIGITS (N_DIGITS),
    .CLK_DIV  (CLK_DIV),
    .DIV_W    (DIV_W),
    .PTR_W    (PTR_W)
  ) u_div (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .o_div_cnt      (div_cnt),
    .o_ptr          (ptr),
    .o_slot_start_c (slot_start_c)
  );

  // PWM compare, masking and polarity feeding the output registers.
  always_comb begin
    bright_d = bright_q;
    if (slot_start_c) bright_d = i_brightness;

    // Low bits of the slot counter act as the PWM ramp.
    phase  = div_cnt[PWM_BITS-1:0];
    pwm_on = (phase < bright_q);
    active = i_en && pwm_on && i_digit_mask[ptr];

    cs_d    = N_DIGITS'(apply_pol(active ? onehot_sel(32'(ptr), N_DIGITS) : '0,
                                  CS_ACTIVE_LOW));
    ptr_d   = ptr;
    frame_d = i_en && (ptr == '0) && slot_start_c;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bright_q <= '0;
      cs_q     <= CS_IDLE;
      ptr_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      bright_q <= bright_d;
      cs_q     <= cs_d;
      ptr_q    <= ptr_d;
      frame_q  <= frame_d;
    end
  end

  assign o_cs          = cs_q;
  assign o_ptr         = ptr_q;
  assign o_frame_start = frame_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench: a 4-digit active-high scanner driven by a phase table,
// and a 5-digit active-low scanner sharing the stimulus, checked per cycle.
module tb_led_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] bright;
  logic [3:0] mask4;
  logic [4:0] mask5;

  logic [3:0] cs4;
  logic [1:0] ptr4;
  logic       fs4;
  logic [4:0] cs5;
  logic [2:0] ptr5;
  logic       fs5;

  led_scan_ctrl #(
    .N_DIGITS(4), .CLK_DIV(16), .PWM_BITS(2), .CS_ACTIVE_LOW(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_brightness(bright),
    .i_digit_mask(mask4), .o_cs(cs4), .o_ptr(ptr4), .o_frame_start(fs4)
  );

  led_scan_ctrl #(
    .N_DIGITS(5), .CLK_DIV(16), .PWM_BITS(2), .CS_ACTIVE_LOW(1'b1)
  ) dut5 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_brightness(bright),
    .i_digit_mask(mask5), .o_cs(cs5), .o_ptr(ptr5), .o_frame_start(fs5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] bright;
    logic [3:0] mask;
    int         cycles;
    int         e0, e1, e2, e3;  // expected active cycles per digit
    int         fs;              // expected frame-start pulses
    int         ptr;             // expected o_ptr after the last cycle
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int on_cnt[4];
  int fs_cnt;
  int prev5 = 0;
  int wrap5 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    logic [4:0] inv5;
    int         nxt;
    for (int i = 0; i < 4; i++) on_cnt[i] += int'(cs4[i]);
    if (fs4) fs_cnt++;
    if (cs4 != 4'd0) check("cs4_onehot_at_ptr", int'(cs4), 1 << ptr4);
    inv5 = ~cs5;
    if (inv5 != 5'd0) check("cs5_low_at_ptr", int'(inv5), 1 << ptr5);
    nxt = (prev5 == 4) ? 0 : prev5 + 1;
    check("ptr5_step", int'((int'(ptr5) == prev5) || (int'(ptr5) == nxt)), 1);
    if (prev5 == 4 && ptr5 == 3'd0) wrap5++;
    prev5 = int'(ptr5);
    if (fs5) check("fs5_at_ptr0", int'(ptr5), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  initial begin
    //           en    br    mask   cyc  d0  d1  d2  d3  fs ptr
    vecs[0] = '{1'b1, 2'd3, 4'hF,  64, 11, 12, 12, 12, 1, 3};
    vecs[1] = '{1'b1, 2'd1, 4'hF,  64,  4,  4,  4,  4, 1, 3};
    vecs[2] = '{1'b1, 2'd0, 4'hF,  64,  1,  0,  0,  0, 1, 3};
    vecs[3] = '{1'b1, 2'd3, 4'hA,  64,  0, 12,  0, 12, 1, 3};
    vecs[4] = '{1'b1, 2'd3, 4'hF,  40, 12, 12,  6,  0, 1, 2};
    vecs[5] = '{1'b0, 2'd3, 4'hF,  10,  0,  0,  0,  0, 0, 2};
    vecs[6] = '{1'b1, 2'd3, 4'hF,  24,  0,  0,  6, 12, 0, 3};
    vecs[7] = '{1'b1, 2'd3, 4'hF,   1,  1,  0,  0,  0, 1, 0};

    rst = 1'b1; en = 1'b0; bright = 2'd0; mask4 = 4'h0; mask5 = 5'h1F;
    #2;
    check("rst_cs4", int'(cs4), 0);
    check("rst_ptr4", int'(ptr4), 0);
    check("rst_fs4", int'(fs4), 0);
    check("rst_cs5", int'(cs5), 31);
    check("rst_ptr5", int'(ptr5), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      en     = vecs[v].en;
      bright = vecs[v].bright;
      mask4  = vecs[v].mask;
      for (int i = 0; i < 4; i++) on_cnt[i] = 0;
      fs_cnt = 0;
      repeat (vecs[v].cycles) step();
      check($sformatf("vec%0d_on0", v), on_cnt[0], vecs[v].e0);
      check($sformatf("vec%0d_on1", v), on_cnt[1], vecs[v].e1);
      check($sformatf("vec%0d_on2", v), on_cnt[2], vecs[v].e2);
      check($sformatf("vec%0d_on3", v), on_cnt[3], vecs[v].e3);
      check($sformatf("vec%0d_frame_start", v), fs_cnt, vecs[v].fs);
      check($sformatf("vec%0d_ptr", v), int'(ptr4), vecs[v].ptr);
    end

    // Scan into slot 2 (div 5), then hit reset between clock edges.
    en = 1'b1; bright = 2'd3; mask4 = 4'hF;
    repeat (37) step();
    check("pre_reset_cs4", int'(cs4), 4);
    check("pre_reset_ptr4", int'(ptr4), 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cs4", int'(cs4), 0);
    check("async_rst_ptr4", int'(ptr4), 0);
    check("async_rst_fs4", int'(fs4), 0);
    check("async_rst_cs5", int'(cs5), 31);
    #1 rst = 1'b0;
    prev5 = 0;

    // First enabled cycle after reset is slot 0, div 0, with brightness still 0.
    step();
    check("post_rst_fs4", int'(fs4), 1);
    check("post_rst_ptr4", int'(ptr4), 0);
    check("post_rst_cs4", int'(cs4), 0);
    step();
    check("post_rst2_cs4", int'(cs4), 1);
    check("post_rst2_fs4", int'(fs4), 0);

    check("ptr5_wrap_seen", int'(wrap5 > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
